// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the instruction fetch sequencer: FSM encoding,
// default address window and the word used for faulted fetches.
package fetch_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_RST   = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_ERR   = 2'd3
  } fetch_state_e;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] DEFAULT_PC_MIN   = 32'h0000_3000;
  localparam logic [31:0] DEFAULT_PC_MAX   = 32'h0000_6ffc;
  localparam logic [31:0] NOP_WORD         = 32'h0000_0000;

  function automatic logic pc_is_legal(input logic [31:0] pc,
                                       input logic [31:0] lo,
                                       input logic [31:0] hi);
    return (pc[1:0] == 2'b00) && (pc >= lo) && (pc <= hi);
  endfunction

endpackage

// File: rtl/fetch_sequencer_buffer.sv
// One-entry holding register between fetch and decode: pc, instruction word
// and address-error flag, with load / consume / flush.
module fetch_buffer
  import fetch_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] load_pc,
  input  logic [31:0] load_instr,
  input  logic        load_adel,
  input  logic        consume,
  input  logic        flush,
  output logic        valid,
  output logic [31:0] pc,
  output logic [31:0] instr,
  output logic        adel
);

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      valid <= 1'b0;
      pc    <= '0;
      instr <= NOP_WORD;
      adel  <= 1'b0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      // A load in the same cycle as a consume replaces the departing entry.
      valid <= 1'b1;
      pc    <= load_pc;
      instr <= load_instr;
      adel  <= load_adel;
    end else if (consume) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// PC owner and fetch sequencer: issues req/ack fetches, applies delay-slot
// redirects and exception flushes, and feeds the one-entry decode buffer.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [31:0] PC_MIN   = DEFAULT_PC_MIN,
  parameter logic [31:0] PC_MAX   = DEFAULT_PC_MAX
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        if_adel,
  input  logic        if_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic [31:0] redirect_target,
  input  logic        flush_valid,
  input  logic [31:0] flush_target
);

  fetch_state_e state, state_next;
  logic [31:0]  pc, pc_next;
  logic         pending_valid, pending_valid_next;
  logic [31:0]  pending_target, pending_target_next;

  logic active, pc_legal, buf_free;
  logic redirect_live, slot_next, slot_done, redirect_hit;
  logic complete, load_err, wrong_path;

  assign active        = (state != ST_RST);
  assign pc_legal      = pc_is_legal(pc, PC_MIN, PC_MAX);
  assign buf_free      = !if_valid || if_ready;
  assign redirect_live = active && redirect_valid && !flush_valid;
  assign slot_next     = (pc == redirect_pc + 32'd4);
  assign slot_done     = (pc == redirect_pc + 32'd8);
  assign redirect_hit  = redirect_live && (slot_next || slot_done);
  // With the delay slot already fetched, pc is on the wrong path: drop its ack.
  assign wrong_path    = redirect_live && slot_done;
  assign complete      = imem_req && imem_ack && !flush_valid && !wrong_path;
  assign load_err      = ((state == ST_FETCH) || (state == ST_HOLD)) && !pc_legal
                         && buf_free && !flush_valid && !wrong_path;

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_RST;
    else       state <= state_next;
  end

  // FSM next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_RST: state_next = ST_FETCH;
      ST_FETCH, ST_HOLD: begin
        if (load_err)                  state_next = ST_ERR;
        else if (if_valid && !if_ready) state_next = ST_HOLD;
        else                           state_next = ST_FETCH;
      end
      ST_ERR: if (redirect_hit) state_next = ST_FETCH;
    endcase
    if (flush_valid) state_next = ST_FETCH;
  end

  // FSM outputs
  always_comb begin
    imem_req  = active && pc_legal && buf_free;
    imem_addr = pc;
  end

  // pc and pending delay-slot target
  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    pc_next             = pc;
    pending_valid_next  = pending_valid;
    pending_target_next = pending_target;
    if (flush_valid) begin
      pc_next            = flush_target;
      pending_valid_next = 1'b0;
    end else begin
      if (complete) begin
        if (pending_valid) begin
          pc_next            = pending_target;
          pending_valid_next = 1'b0;
        end else begin
          pc_next = pc + 32'd4;
        end
      end
      if (redirect_live && slot_next) begin
        if (complete) begin
          pc_next = redirect_target;
        end else begin
          pending_valid_next  = 1'b1;
          pending_target_next = redirect_target;
        end
      end else if (redirect_live && slot_done) begin
        pc_next            = redirect_target;
        pending_valid_next = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc             <= RESET_PC;
      pending_valid  <= 1'b0;
      pending_target <= '0;
    end else begin
      pc             <= pc_next;
      pending_valid  <= pending_valid_next;
      pending_target <= pending_target_next;
    end
  end

  fetch_buffer u_buffer (
    .clk        (clk),
    .reset      (reset),
    .load       (complete || load_err),
    .load_pc    (pc),
    .load_instr (complete ? imem_rdata : NOP_WORD),
    .load_adel  (!complete),
    .consume    (if_ready),
    .flush      (flush_valid),
    .valid      (if_valid),
    .pc         (if_pc),
    .instr      (if_instr),
    .adel       (if_adel)
  );

  // A redirect must name the branch whose delay slot is at pc or just behind it.
  assert property (@(posedge clk) disable iff (reset) redirect_live |-> redirect_hit)
    else $error("fetch_sequencer: redirect_pc %h inconsistent with pc %h", redirect_pc, pc);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios with literal
// expectations, then randomized traffic against a fetch-order queue model.
module tb_fetch_sequencer;

  localparam logic [31:0] LO  = 32'h0000_3000;
  localparam logic [31:0] HI  = 32'h0000_6ffc;
  localparam logic [31:0] RPC = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_adel;
  logic        if_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] redirect_target;
  logic        flush_valid;
  logic [31:0] flush_target;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: queue of addresses still to fetch in program order, plus buffer.
  logic [31:0] m_q[$];
  logic        m_known = 1'b0;
  logic        m_started, m_err;
  logic        m_bv, m_badel;
  logic [31:0] m_bpc, m_binstr;

  always #5 clk = ~clk;

  fetch_sequencer dut (
    .clk             (clk),
    .reset           (reset),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .if_valid        (if_valid),
    .if_pc           (if_pc),
    .if_instr        (if_instr),
    .if_adel         (if_adel),
    .if_ready        (if_ready),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .redirect_target (redirect_target),
    .flush_valid     (flush_valid),
    .flush_target    (flush_target)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5a5a, ~a[15:0]};
  endfunction

  assign imem_rdata = imem_ack ? mem_word(imem_addr) : 32'hdead_beef;

  function automatic logic addr_legal(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a >= LO) && (a <= HI);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q       = {RPC};
    m_known   = 1'b1;
    m_started = 1'b0;
    m_err     = 1'b0;
    m_bv      = 1'b0;
    m_bpc     = '0;
    m_binstr  = '0;
    m_badel   = 1'b0;
  endtask

  task automatic model_step();
    logic [31:0] head;
    logic free, req, hit4, hit8, comp, errload;
    head    = m_q[0];
    free    = !m_bv || if_ready;
    req     = m_started && addr_legal(head) && free;
    hit4    = m_started && redirect_valid && !flush_valid && (head == redirect_pc + 32'd4);
    hit8    = m_started && redirect_valid && !flush_valid && (head == redirect_pc + 32'd8);
    comp    = req && imem_ack && !flush_valid && !hit8;
    errload = m_started && !m_err && !addr_legal(head) && free && !flush_valid && !hit8;

    if (flush_valid) m_bv = 1'b0;
    else if (comp) begin
      m_bv = 1'b1; m_bpc = head; m_binstr = mem_word(head); m_badel = 1'b0;
    end else if (errload) begin
      m_bv = 1'b1; m_bpc = head; m_binstr = 32'h0; m_badel = 1'b1;
    end else if (m_bv && if_ready) m_bv = 1'b0;

    if (flush_valid) begin
      m_q   = {flush_target};
      m_err = 1'b0;
    end else begin
      if (comp) void'(m_q.pop_front());
      if (hit4) m_q = comp ? {redirect_target} : {head, redirect_target};
      if (hit8) m_q = {redirect_target};
      if (m_q.size() == 0) m_q.push_back(head + 32'd4);
      if (hit4 || hit8) m_err = 1'b0;
      if (errload) m_err = 1'b1;
    end
    m_started = 1'b1;
  endtask

  // Compare process: every cycle, DUT outputs against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (m_known) begin
        check("imem_req", 32'(imem_req),
              32'(m_started && addr_legal(m_q[0]) && (!m_bv || if_ready)));
        check("imem_addr", imem_addr, m_q[0]);
        check("if_valid", 32'(if_valid), 32'(m_bv));
        if (m_bv) begin
          check("if_pc", if_pc, m_bpc);
          check("if_instr", if_instr, m_binstr);
          check("if_adel", 32'(if_adel), 32'(m_badel));
        end
      end
      if (reset) model_reset();
      else if (m_known) model_step();
    end
  end

  task automatic begin_cycle(input logic ack, input logic rdy);
    @(posedge clk); #1;
    reset = 1'b0; imem_ack = ack; if_ready = rdy;
    redirect_valid = 1'b0; flush_valid = 1'b0;
  endtask

  task automatic redirect(input logic [31:0] rpc, input logic [31:0] tgt);
    redirect_valid = 1'b1; redirect_pc = rpc; redirect_target = tgt;
  endtask

  task automatic flush(input logic [31:0] tgt);
    flush_valid = 1'b1; flush_target = tgt;
  endtask

  task automatic expect_fetch(input string tag, input logic req, input logic [31:0] addr);
    check({tag, "_req"}, 32'(imem_req), 32'(req));
    check({tag, "_addr"}, imem_addr, addr);
  endtask

  task automatic expect_buf(input string tag, input logic [31:0] pc, input logic adel);
    check({tag, "_valid"}, 32'(if_valid), 32'd1);
    check({tag, "_pc"}, if_pc, pc);
    check({tag, "_adel"}, 32'(if_adel), 32'(adel));
    check({tag, "_instr"}, if_instr, adel ? 32'h0 : mem_word(pc));
  endtask

  function automatic logic [31:0] rand_target();
    case ($urandom_range(0, 9))
      0:       return LO - 32'd4;
      1:       return HI + 32'd4;
      2:       return (LO + ($urandom_range(0, 16'h0fff) << 2)) | 32'($urandom_range(1, 3));
      3:       return HI;
      4:       return LO;
      default: return LO + ($urandom_range(0, 16'h0fff) << 2);
    endcase
  endfunction

  initial begin
    reset = 1'b1; imem_ack = 1'b0; if_ready = 1'b1;
    redirect_valid = 1'b0; redirect_pc = '0; redirect_target = '0;
    flush_valid = 1'b0; flush_target = '0;
    @(posedge clk);

    // Reset state: first cycle after reset has no request.
    begin_cycle(1'b1, 1'b1);
    @(negedge clk);
    expect_fetch("rst", 1'b0, 32'h3000);
    check("rst_valid", 32'(if_valid), 32'd0);
    check("rst_pc", if_pc, 32'h0);
    check("rst_instr", if_instr, 32'h0);
    check("rst_adel", 32'(if_adel), 32'd0);

    begin_cycle(1'b1, 1'b1); @(negedge clk);
    expect_fetch("seq0", 1'b1, 32'h3000);
    check("seq0_valid", 32'(if_valid), 32'd0);
    begin_cycle(1'b1, 1'b1); @(negedge clk);
    expect_fetch("seq1", 1'b1, 32'h3004); expect_buf("seq1", 32'h3000, 1'b0);
    begin_cycle(1'b1, 1'b1); @(negedge clk);
    expect_fetch("seq2", 1'b1, 32'h3008); expect_buf("seq2", 32'h3004, 1'b0);

    // Stall: buffer holds 3008, pc holds 300c.
    for (int i = 0; i < 3; i++) begin
      begin_cycle(1'b1, 1'b0); @(negedge clk);
      expect_fetch("stall", 1'b0, 32'h300c); expect_buf("stall", 32'h3008, 1'b0);
    end
    begin_cycle(1'b1, 1'b1); @(negedge clk);
    expect_fetch("resume", 1'b1, 32'h300c); expect_buf("resume", 32'h3008, 1'b0);
    begin_cycle(1'b1, 1'b1); @(negedge clk);
    expect_fetch("run1", 1'b1, 32'h3010);
    begin_cycle(1'b0, 1'b1); redirect(32'h3010, 32'h3100); @(negedge clk);
    expect_fetch("rd4", 1'b1, 32'h3014);
    begin_cycle(1'b1, 1'b1); @(negedge clk);
    expect_fetch("rd4_slot", 1'b1, 32'h3014);
    check("rd4_slot_valid", 32'(if_valid), 32'd0);
    begin_cycle(1'b1, 1'b1); @(negedge clk);
    expect_fetch("rd4_tgt", 1'b1, 32'h3100); expect_buf("rd4_tgt", 32'h3014, 1'b0);

    // Redirect with the delay slot already fetched.
    begin_cycle(1'b0, 1'b1); flush(32'h3010); @(negedge clk);
    begin_cycle(1'b1, 1'b1); @(negedge clk);
    expect_fetch("fl1", 1'b1, 32'h3010);
    check("fl1_valid", 32'(if_valid), 32'd0);
    begin_cycle(1'b1, 1'b1); @(negedge clk);
    begin_cycle(1'b0, 1'b1); redirect(32'h3010, 32'h3100); @(negedge clk);
    expect_fetch("rd8", 1'b1, 32'h3018); expect_buf("rd8", 32'h3014, 1'b0);
    begin_cycle(1'b1, 1'b1); @(negedge clk);
    expect_fetch("rd8_tgt", 1'b1, 32'h3100);
    check("rd8_valid", 32'(if_valid), 32'd0);

    // Flush together with ack and redirect: flush wins, ack dropped.
    begin_cycle(1'b1, 1'b1); flush(32'h4180); redirect(32'h3100, 32'h3200); @(negedge clk);
    expect_fetch("flx", 1'b1, 32'h3104);
    begin_cycle(1'b1, 1'b1); @(negedge clk);
    expect_fetch("flx_next", 1'b1, 32'h4180);
    check("flx_valid", 32'(if_valid), 32'd0);

    // Redirect to a misaligned target.
    begin_cycle(1'b1, 1'b1); redirect(32'h4180, 32'h3102); @(negedge clk);
    expect_fetch("mis", 1'b1, 32'h4184); expect_buf("mis", 32'h4180, 1'b0);
    begin_cycle(1'b1, 1'b1); @(negedge clk);
    expect_fetch("mis_hold", 1'b0, 32'h3102); expect_buf("mis_slot", 32'h4184, 1'b0);
    begin_cycle(1'b1, 1'b1); @(negedge clk);
    expect_fetch("mis_err", 1'b0, 32'h3102); expect_buf("mis_err", 32'h3102, 1'b1);
    begin_cycle(1'b1, 1'b1); flush(32'h6ff8); @(negedge clk);
    check("err_once", 32'(if_valid), 32'd0);

    // Walk across the top of the legal window into 7000.
    begin_cycle(1'b1, 1'b1); @(negedge clk);
    expect_fetch("top0", 1'b1, 32'h6ff8);
    begin_cycle(1'b1, 1'b1); @(negedge clk);
    expect_fetch("top1", 1'b1, 32'h6ffc);
    begin_cycle(1'b1, 1'b1); @(negedge clk);
    expect_fetch("top2", 1'b0, 32'h7000); expect_buf("top2", 32'h6ffc, 1'b0);
    begin_cycle(1'b1, 1'b1); redirect(32'h6ff8, 32'h3000); @(negedge clk);
    expect_buf("top_err", 32'h7000, 1'b1);
    begin_cycle(1'b1, 1'b1); @(negedge clk);
    expect_fetch("err_exit", 1'b1, 32'h3000);

    // Randomized traffic against the model.
    @(posedge clk); #1; reset = 1'b1; redirect_valid = 1'b0; flush_valid = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #1;
      reset           = ($urandom_range(0, 599) == 0);
      imem_ack        = ($urandom_range(0, 9) < 7);
      if_ready        = ($urandom_range(0, 3) != 0);
      flush_valid     = !reset && ($urandom_range(0, 39) == 0);
      flush_target    = rand_target();
      redirect_valid  = 1'b0;
      redirect_pc     = $urandom;
      redirect_target = rand_target();
      if (!reset && m_started && !m_err && m_q.size() == 1 && addr_legal(m_q[0])
          && $urandom_range(0, 5) == 0) begin
        redirect_valid = 1'b1;
        redirect_pc    = m_q[0] - (($urandom_range(0, 1) == 1) ? 32'd4 : 32'd8);
      end
    end
    @(posedge clk); #1; redirect_valid = 1'b0; flush_valid = 1'b0; reset = 1'b0;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
